// File: rtl/regfile_bist.sv
// Built-in self-test controller for a 2**ADDR_WIDTH x DATA_WIDTH register file.
// Optional second pass with inverted pattern: define REGFILE_BIST_INVERT_PASS_EN.
module regfile_bist #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG0  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] writeAdrx,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  writeEn,
  output logic [ADDR_WIDTH-1:0] rdAdrx0,
  output logic [ADDR_WIDTH-1:0] rdAdrx1,
  input  logic [DATA_WIDTH-1:0] rdData0,
  input  logic [DATA_WIDTH-1:0] rdData1,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] errCount,
  output logic [ADDR_WIDTH-1:0] failAdrx
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int HALF     = NUM_REGS / 2;
  localparam int EW       = ADDR_WIDTH + 2;

  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'(HALF - 1);
  localparam logic [ADDR_WIDTH-1:0] HALF_ADDR = ADDR_WIDTH'(HALF);

`ifdef REGFILE_BIST_INVERT_PASS_EN
  localparam bit TWO_PASS = 1'b1;
`else
  localparam bit TWO_PASS = 1'b0;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic                  inv_pass;
  logic                  comparing;
  logic                  miss0;
  logic                  miss1;
  logic [EW:0]           err_sum;
  logic [EW-1:0]         err_next;
  logic [ADDR_WIDTH-1:0] fail_next;
  logic [ADDR_WIDTH-1:0] wr_next;
  logic [ADDR_WIDTH-1:0] rd_next;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic                  inv);
    logic [DATA_WIDTH-1:0] v;
    v = DATA_WIDTH'(a) + DATA_WIDTH'(1);
    return inv ? ~v : v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] expected(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic                  inv);
    if (ZERO_REG0 && a == '0) return '0;
    return pattern(a, inv);
  endfunction

  // The read addresses are registered, so the data on rdData* always belongs
  // to the pair driven on the previous edge: compare during READ and DRAIN.
  assign comparing = (state == S_READ) || (state == S_DRAIN);
  assign miss0     = comparing && (rdData0 != expected(rdAdrx0, inv_pass));
  assign miss1     = comparing && (rdData1 != expected(rdAdrx1, inv_pass));
  assign err_sum   = {1'b0, errCount} + {{EW{1'b0}}, miss0} + {{EW{1'b0}}, miss1};
  assign err_next  = err_sum[EW] ? {EW{1'b1}} : err_sum[EW-1:0];
  assign wr_next   = writeAdrx + ONE_A;
  assign rd_next   = rdAdrx0 + ONE_A;

  // A zero count means no mismatch has been recorded yet in this test.
  always_comb begin
    // NOTE: default first so every path assigns fail_next and no latch is inferred.
    fail_next = failAdrx;
    if (errCount == '0) begin
      if (miss0)      fail_next = rdAdrx0;
      else if (miss1) fail_next = rdAdrx1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      inv_pass  <= 1'b0;
      writeAdrx <= '0;
      writeData <= '0;
      writeEn   <= 1'b0;
      rdAdrx0   <= '0;
      rdAdrx1   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      errCount  <= '0;
      failAdrx  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_WRITE;
            inv_pass  <= 1'b0;
            errCount  <= '0;
            failAdrx  <= '0;
            pass      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            writeEn   <= 1'b1;
            writeAdrx <= '0;
            writeData <= pattern('0, 1'b0);
          end
        end
        S_WRITE: begin
          if (writeAdrx == LAST_ADDR) begin
            writeEn <= 1'b0;
            rdAdrx0 <= '0;
            rdAdrx1 <= HALF_ADDR;
            state   <= (HALF == 1) ? S_DRAIN : S_READ;
          end else begin
            writeAdrx <= wr_next;
            writeData <= pattern(wr_next, inv_pass);
          end
        end
        S_READ: begin
          errCount <= err_next;
          failAdrx <= fail_next;
          rdAdrx0  <= rd_next;
          rdAdrx1  <= rdAdrx1 + ONE_A;
          if (rd_next == LAST_PAIR) state <= S_DRAIN;
        end
        S_DRAIN: begin
          errCount <= err_next;
          failAdrx <= fail_next;
          if (TWO_PASS && !inv_pass) begin
            state     <= S_WRITE;
            inv_pass  <= 1'b1;
            writeEn   <= 1'b1;
            writeAdrx <= '0;
            writeData <= pattern('0, 1'b1);
          end else begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// Self-checking bench for regfile_bist: two instances (ZERO_REG0 = 0 and 1) on
// fault-injectable register file models, checked against an outcome predictor.
module tb_regfile_bist;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int EW = AW + 2;
`ifdef REGFILE_BIST_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic [AW-1:0] a_wadr, a_rd0, a_rd1, a_fail, z_wadr, z_rd0, z_rd1, z_fail;
  logic [DW-1:0] a_wdata, a_rdata0, a_rdata1, z_wdata, z_rdata0, z_rdata1;
  logic          a_we, a_busy, a_done, a_pass, z_we, z_busy, z_done, z_pass;
  logic [EW-1:0] a_err, z_err;

  regfile_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG0(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .writeAdrx(a_wadr), .writeData(a_wdata), .writeEn(a_we),
    .rdAdrx0(a_rd0), .rdAdrx1(a_rd1), .rdData0(a_rdata0), .rdData1(a_rdata1),
    .busy(a_busy), .done(a_done), .pass(a_pass), .errCount(a_err), .failAdrx(a_fail)
  );

  regfile_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG0(1'b1)) dut_z (
    .clk(clk), .rst(rst), .start(start),
    .writeAdrx(z_wadr), .writeData(z_wdata), .writeEn(z_we),
    .rdAdrx0(z_rd0), .rdAdrx1(z_rd1), .rdData0(z_rdata0), .rdData1(z_rdata1),
    .busy(z_busy), .done(z_done), .pass(z_pass), .errCount(z_err), .failAdrx(z_fail)
  );

  // Register file models with per-register stuck-at masks and optional hardwired r0.
  logic [DW-1:0] mem_a [NR];
  logic [DW-1:0] mem_z [NR];
  logic [DW-1:0] st0 [NR];
  logic [DW-1:0] st1 [NR];
  bit            r0_hard;

  function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v);
    if (r0_hard && a == 0) return '0;
    return (v & ~st0[a]) | st1[a];
  endfunction

  always @(posedge clk) begin
    if (a_we === 1'b1) mem_a[a_wadr] <= faulty(int'(a_wadr), a_wdata);
    if (z_we === 1'b1) mem_z[z_wadr] <= faulty(int'(z_wadr), z_wdata);
  end
  assign a_rdata0 = mem_a[a_rd0];
  assign a_rdata1 = mem_a[a_rd1];
  assign z_rdata0 = mem_z[z_rd0];
  assign z_rdata1 = mem_z[z_rd1];

  logic [AW+DW-1:0] wlog[$];
  always @(negedge clk) if (a_we === 1'b1) wlog.push_back({a_wadr, a_wdata});

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a, input int p);
    logic [DW-1:0] v;
    v = DW'(a + 1);
    return (p != 0) ? ~v : v;
  endfunction

  // Outcome predictor: walk the compare order (pairs j / j+NR/2, port 0 first)
  // and count what the faulty register file would return versus the ideal value.
  task automatic predict(input bit zero, output int errs, output int fail, output bit ok);
    int cnt;
    int a;
    logic [DW-1:0] expv;
    cnt  = 0;
    fail = 0;
    for (int p = 0; p < NPASS; p++)
      for (int j = 0; j < NR / 2; j++)
        for (int port = 0; port < 2; port++) begin
          a    = j + port * (NR / 2);
          expv = (zero && a == 0) ? '0 : pat(a, p);
          if (faulty(a, pat(a, p)) !== expv) begin
            if (cnt == 0) fail = a;
            cnt++;
          end
        end
    errs = (cnt > 127) ? 127 : cnt;
    ok   = (cnt == 0);
  endtask

  task automatic clear_faults();
    for (int i = 0; i < NR; i++) begin
      st0[i] = '0;
      st1[i] = '0;
    end
    r0_hard = 1'b0;
  endtask

  task automatic run_bist(input string tag, input int pulse_at);
    int cyc;
    int done_at;
    int bad;
    int e_err, e_fail;
    bit e_ok;
    wlog.delete();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "/edge0_busy"}, a_busy, 1'b1);
    check({tag, "/edge0_we"}, a_we, 1'b1);
    check({tag, "/edge0_wadr"}, a_wadr, 0);
    cyc     = 0;
    done_at = -1;
    while (cyc < 400 && done_at < 0) begin
      @(negedge clk) start = (cyc + 1 == pulse_at);
      @(posedge clk);
      cyc++;
      #1;
      if (a_done === 1'b1) done_at = cyc;
    end
    start = 1'b0;
    check({tag, "/done_edge"}, done_at, 48 * NPASS);
    check({tag, "/z_done"}, z_done, 1'b1);
    check({tag, "/busy_off"}, a_busy, 1'b0);
    predict(1'b0, e_err, e_fail, e_ok);
    check({tag, "/pass"}, a_pass, e_ok);
    check({tag, "/err"}, a_err, e_err);
    check({tag, "/fail"}, a_fail, e_fail);
    predict(1'b1, e_err, e_fail, e_ok);
    check({tag, "/z_pass"}, z_pass, e_ok);
    check({tag, "/z_err"}, z_err, e_err);
    check({tag, "/z_fail"}, z_fail, e_fail);
    check({tag, "/wr_count"}, wlog.size(), NR * NPASS);
    bad = 0;
    for (int k = 0; k < wlog.size(); k++)
      if (wlog[k] !== {AW'(k % NR), pat(k % NR, k / NR)}) bad++;
    check({tag, "/wr_bad"}, bad, 0);
`ifdef REGFILE_BIST_INVERT_PASS_EN
    if (wlog.size() > NR) check({tag, "/wr_inv0"}, wlog[NR][DW-1:0], 32'hFFFFFFFE);
`endif
    repeat (2) @(posedge clk);
    #1 check({tag, "/done_hold"}, a_done, 1'b1);
  endtask

  initial begin
    int n;
    int r;
    int d1, d2, cyc;
    bit prev;
    for (int i = 0; i < NR; i++) begin
      mem_a[i] = '0;
      mem_z[i] = '0;
    end
    clear_faults();
    start = 1'b0;
    rst   = 1'b1;
    #1;
    check("reset_we", a_we, 1'b0);
    check("reset_busy", a_busy, 1'b0);
    check("reset_done", a_done, 1'b0);
    check("reset_err", a_err, 0);
    check("reset_rd1", a_rd1, 0);
    #20 @(negedge clk) rst = 1'b0;

    run_bist("clean", -1);
    st0[5] = 32'h8;
    run_bist("stuck_r5_b3", -1);
    clear_faults();
    st0[9] = 32'h8;
    run_bist("stuck_r9_b3", -1);
    clear_faults();
    st0[2]  = 32'h1;
    st0[18] = 32'h1;
    run_bist("stuck_r2_r18", -1);
    clear_faults();
    r0_hard = 1'b1;
    run_bist("r0_hard", -1);
    clear_faults();
    run_bist("start_while_busy", 10);

    // Asynchronous reset in the middle of a cycle, mid-WRITE.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 check("pre_rst_we", a_we, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_we", a_we, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_wadr", a_wadr, 0);
    check("rst_wdata", a_wdata, 0);
    @(negedge clk) rst = 1'b0;
    run_bist("after_rst", -1);

    for (int it = 0; it < 6; it++) begin
      clear_faults();
      n = $urandom_range(0, 3);
      for (int f = 0; f < n; f++) begin
        r = $urandom_range(0, NR - 1);
        if ($urandom_range(0, 1) == 0) st0[r] = st0[r] | (32'h1 << $urandom_range(0, 7));
        else                           st1[r] = st1[r] | (32'h1 << $urandom_range(0, 31));
      end
      r0_hard = ($urandom_range(0, 3) == 0);
      run_bist($sformatf("rand%0d", it), -1);
    end
    clear_faults();

    // start held high restarts the test one edge after every completion.
    @(negedge clk) start = 1'b1;
    d1   = -1;
    d2   = -1;
    cyc  = 0;
    prev = a_done;
    while (cyc < 600 && d2 < 0) begin
      @(posedge clk);
      cyc++;
      #1;
      if (a_done === 1'b1 && !prev) begin
        if (d1 < 0) d1 = cyc;
        else        d2 = cyc;
      end
      prev = a_done;
    end
    check("held_start_gap", d2 - d1, 48 * NPASS + 1);
    @(negedge clk) start = 1'b0;
    run_bist("final", -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
